// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with shared prescaler and counter, edge- or center-aligned.
// Configuration lives in live registers that are copied to shadows at each period boundary.
module pwm_multi #(
  parameter int NUM_CH  = 4,
  parameter int RES     = 8,
  parameter int PRESC_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [15:0]       wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam logic [RES-1:0] MAXM1 = {{(RES-1){1'b1}}, 1'b0};

  logic               r_mode, r_mode_sh;
  logic [PRESC_W-1:0] r_presc, r_presc_sh;
  logic [NUM_CH-1:0]  r_ch_en, r_ch_en_sh;
  logic [NUM_CH-1:0]  r_out_en;
  logic [RES-1:0]     r_duty    [NUM_CH];
  logic [RES-1:0]     r_duty_sh [NUM_CH];
  logic [PRESC_W-1:0] r_pre;
  logic [RES-1:0]     r_cnt;
  logic               r_dir;
  logic [NUM_CH-1:0]  r_pwm;
  logic               r_tick;

  logic               w_tick;
  logic               w_bnd;
  logic [NUM_CH-1:0]  w_pwm_nxt;
  logic               w_unused;

  assign w_unused = &{1'b0, wr_data};
  assign w_tick   = (r_pre == r_presc_sh);
  // Edge mode ends after cnt=MAX-1; center mode ends at the bottom of the down ramp.
  assign w_bnd    = ena & w_tick & (r_mode_sh ? (r_dir & (r_cnt == '0)) : (r_cnt == MAXM1));

  always_comb begin
    w_pwm_nxt = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_pwm_nxt[i] = r_out_en[i] & r_ch_en_sh[i] & (r_cnt < r_duty_sh[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= 1'b0;
      r_presc  <= '0;
      r_ch_en  <= '0;
      r_out_en <= '0;
      for (int i = 0; i < NUM_CH; i++) r_duty[i] <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        4'h0:    r_mode   <= wr_data[0];
        4'h1:    r_presc  <= wr_data[PRESC_W-1:0];
        4'h2:    r_ch_en  <= wr_data[NUM_CH-1:0];
        4'h3:    r_out_en <= wr_data[NUM_CH-1:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++)
        if (wr_addr == 4'(i + 4)) r_duty[i] <= wr_data[RES-1:0];
    end
  end

  // Shadows track live values while idle and latch the pre-write values at a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_sh  <= 1'b0;
      r_presc_sh <= '0;
      r_ch_en_sh <= '0;
      for (int i = 0; i < NUM_CH; i++) r_duty_sh[i] <= '0;
    end else if (!ena || w_bnd) begin
      r_mode_sh  <= r_mode;
      r_presc_sh <= r_presc;
      r_ch_en_sh <= r_ch_en;
      for (int i = 0; i < NUM_CH; i++) r_duty_sh[i] <= r_duty[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else if (!ena) begin
      r_pre <= '0;
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else if (w_tick) begin
      r_pre <= '0;
      if (w_bnd) begin
        r_cnt <= '0;
        r_dir <= 1'b0;
      end else if (!r_mode_sh) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!r_dir) begin
        // Top of the up ramp: hold the count one tick while turning around.
        if (r_cnt == MAXM1) r_dir <= 1'b1;
        else                r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm  <= '0;
      r_tick <= 1'b0;
    end else if (!ena) begin
      r_pwm  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pwm  <= w_pwm_nxt;
      r_tick <= w_bnd;
    end
  end

  assign pwm_out     = r_pwm;
  assign period_tick = r_tick;

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of PWM channels (legal 1..12).
REQ-002 SHALL have parameter RES, default 8, duty/counter resolution in bits (legal 2..16); MAX = 2^RES-1.
REQ-003 SHALL have parameter PRESC_W, default 12, prescaler width in bits (legal 1..16).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ena  input  1  global run enable.
REQ-007 SHALL have port wr_en  input  1  register write strobe, one write per high cycle.
REQ-008 SHALL have port wr_addr  input  4  register address.
REQ-009 SHALL have port wr_data  input  16  write data, LSB-aligned, upper bits ignored per register.
REQ-010 SHALL have port pwm_out  output  NUM_CH  registered PWM outputs.
REQ-011 SHALL have port period_tick  output  1  one-cycle pulse per completed PWM period.

Function
REQ-012 SHALL decode writes: 0x0 CTRL (bit0 mode: 0 edge, 1 center), 0x1 PRESC[PRESC_W-1:0], 0x2 CH_EN[NUM_CH-1:0], 0x3 OUT_EN[NUM_CH-1:0], 0x4+i DUTY_i[RES-1:0]; writes to other addresses, or 0x4+i with i>=NUM_CH, SHALL be ignored.
REQ-013 SHALL hold CTRL, PRESC, CH_EN, DUTY_i in live registers and shadow copies; counting and comparison use shadows only; OUT_EN has no shadow and is used directly.
REQ-014 Prescaler SHALL count 0..PRESC_sh and assert internal tick when equal to PRESC_sh (tick every PRESC_sh+1 cycles; PRESC_sh=0 -> every cycle).
REQ-015 Edge mode: counter cnt SHALL advance 0,1,..,MAX-1 on ticks, then wrap to 0; period = MAX ticks.
REQ-016 Center mode: cnt SHALL run up 0..MAX-1, hold one tick while direction flips to down, run down MAX-1..0, hold one tick while flipping to up; period = 2*MAX ticks, each value visited twice.
REQ-017 Boundary event B SHALL occur on a tick when ena=1 and (edge: cnt=MAX-1) or (center: dir=down and cnt=0).
REQ-018 On B: cnt<=0, dir<=up, prescaler<=0, all shadows<=live values, period_tick<=1 next cycle; otherwise period_tick<=0.
REQ-019 Write and B in same cycle: shadow SHALL load the pre-write live value; new value takes effect at the following B.
REQ-020 Mode change SHALL take effect only at B (via shadow); no mid-period mode switch.
REQ-021 pwm_out[i] SHALL be registered as OUT_EN[i] & CH_EN_sh[i] & (cnt < DUTY_sh[i]), one-cycle latency from cnt/OUT_EN.
REQ-022 DUTY=0 SHALL give constant low; DUTY=MAX SHALL give constant high with no glitch across B.
REQ-023 Edge-mode high time SHALL be DUTY ticks per MAX; center-mode high time 2*DUTY ticks per 2*MAX, contiguous across B.
REQ-024 ena=0 SHALL synchronously clear cnt, dir, prescaler, pwm_out, period_tick on next edge and copy live->shadow every cycle; live registers retain values and writes still accepted.
REQ-025 ena 0->1 SHALL start a fresh period at cnt=0, dir=up, with current live values already in shadows.

Reset
REQ-026 rst_n=0 SHALL immediately clear all live and shadow registers, cnt, dir, prescaler, pwm_out=0, period_tick=0, independent of clk.
REQ-027 Reset asserted mid-period SHALL abort the period; after release, block idles until ena=1 and registers are rewritten.

Verification
REQ-028 Reset: rst_n low mid-period with pwm_out=0x1 -> pwm_out=0, period_tick=0 before next clk edge; all registers read back as zero-effect (DUTY=0 -> low).
REQ-029 Edge (NUM_CH=4, RES=8): PRESC=0, DUTY_0=64, CH_EN=OUT_EN=0x1, ena=1 -> pwm_out[0] high 64 of every 255 cycles; period_tick every 255 cycles.
REQ-030 Extremes: DUTY_1=0, DUTY_2=255, CH_EN=OUT_EN=0x6 -> pwm_out[1] constant 0, pwm_out[2] constant 1 across 3 periods.
REQ-031 Center: CTRL=1, PRESC=1, DUTY_0=10 -> period 1020 cycles, pwm_out[0] high 40 contiguous cycles spanning each period_tick.
REQ-032 Shadow: DUTY_0=64 running, write 200 mid-period -> current period 64, next 200; write coinciding with B -> takes effect one period later.
REQ-033 Gating/decode: clear OUT_EN[0] mid-period -> pwm_out[0] low next cycle; write 0xF and 0x4+5 -> no state change.
